// File: rtl/memory_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single shared memory.
// Each port has a one-entry pending slot; ties are resolved round-robin; mem_* and valids are registered.
module memory_arbiter #(
  parameter bit FIRST_GRANT_DATA = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  input  logic        i_flush,
  output logic [31:0] i_inst,
  output logic        i_valid,
  input  logic        d_start,
  input  logic        d_write,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [31:0] d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_rdata_valid,
  output logic        mem_start,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_wmask,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_data_q, last_data_d;
  logic        drop_q, drop_d;
  logic        i_pend_q, i_pend_d;
  logic [31:0] i_slot_addr_q, i_slot_addr_d;
  logic        d_pend_q, d_pend_d;
  logic        d_slot_write_q, d_slot_write_d;
  logic [31:0] d_slot_addr_q, d_slot_addr_d;
  logic [31:0] d_slot_wdata_q, d_slot_wdata_d;
  logic [31:0] d_slot_wmask_q, d_slot_wmask_d;
  logic        mem_start_q, mem_start_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] mem_wmask_q, mem_wmask_d;
  logic [31:0] i_inst_q, i_inst_d;
  logic        i_valid_q, i_valid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_rdata_valid_q, d_rdata_valid_d;

  logic i_busy_s, d_busy_s, i_pend_live_s, grant_data_s;

  // owner_q: 1 = data port owns the in-flight transaction, 0 = instruction port
  assign i_busy_s      = (state_q != IDLE) && !owner_q;
  assign d_busy_s      = (state_q != IDLE) && owner_q;
  assign i_ready       = !i_pend_q && !i_busy_s;
  assign d_ready       = !d_pend_q && !d_busy_s;
  assign i_pend_live_s = i_pend_q && !(i_flush && !i_busy_s);
  assign grant_data_s  = d_pend_q && (!i_pend_live_s || !last_data_q);

  assign mem_start     = mem_start_q;
  assign mem_write     = mem_write_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;
  assign i_inst        = i_inst_q;
  assign i_valid       = i_valid_q;
  assign d_rdata       = d_rdata_q;
  assign d_rdata_valid = d_rdata_valid_q;

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_data_d     = last_data_q;
    drop_d          = drop_q;
    i_pend_d        = i_pend_q;
    i_slot_addr_d   = i_slot_addr_q;
    d_pend_d        = d_pend_q;
    d_slot_write_d  = d_slot_write_q;
    d_slot_addr_d   = d_slot_addr_q;
    d_slot_wdata_d  = d_slot_wdata_q;
    d_slot_wmask_d  = d_slot_wmask_q;
    mem_start_d     = mem_start_q;
    mem_write_d     = mem_write_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wmask_d     = mem_wmask_q;
    i_inst_d        = i_inst_q;
    i_valid_d       = 1'b0;
    d_rdata_d       = d_rdata_q;
    d_rdata_valid_d = 1'b0;

    if (i_start && i_ready) begin
      i_pend_d      = 1'b1;
      i_slot_addr_d = i_addr;
    end else if (i_flush && !i_busy_s) begin
      i_pend_d = 1'b0;
    end else begin
      i_pend_d = i_pend_q;
    end

    if (d_start && d_ready) begin
      d_pend_d       = 1'b1;
      d_slot_write_d = d_write;
      d_slot_addr_d  = d_addr;
      d_slot_wdata_d = d_wdata;
      d_slot_wmask_d = d_wmask;
    end else begin
      d_pend_d = d_pend_q;
    end

    case (state_q)
      IDLE: begin
        if (i_pend_live_s || d_pend_q) begin
          // Round-robin pointer only advances on a genuine tie.
          if (i_pend_live_s && d_pend_q) begin
            last_data_d = grant_data_s;
          end else begin
            last_data_d = last_data_q;
          end
          owner_d     = grant_data_s;
          drop_d      = 1'b0;
          state_d     = ISSUE;
          mem_start_d = 1'b1;
          mem_write_d = grant_data_s ? d_slot_write_q : 1'b0;
          mem_addr_d  = grant_data_s ? d_slot_addr_q : i_slot_addr_q;
          mem_wdata_d = grant_data_s ? d_slot_wdata_q : 32'd0;
          mem_wmask_d = grant_data_s ? d_slot_wmask_q : 32'd0;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (!owner_q && i_flush) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
        if (mem_ready) begin
          mem_start_d = 1'b0;
          state_d     = mem_write_q ? IDLE : WAIT_RESP;
          if (owner_q) begin
            d_pend_d = 1'b0;
          end else begin
            i_pend_d = 1'b0;
          end
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT_RESP: begin
        if (!owner_q && i_flush) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
        if (mem_rdata_valid) begin
          state_d = IDLE;
          if (owner_q) begin
            d_rdata_d       = mem_rdata;
            d_rdata_valid_d = 1'b1;
          end else if (!(drop_q || i_flush)) begin
            i_inst_d  = mem_rdata;
            i_valid_d = 1'b1;
          end else begin
            i_valid_d = 1'b0;
          end
        end else begin
          state_d = WAIT_RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      owner_q         <= 1'b0;
      last_data_q     <= !FIRST_GRANT_DATA;
      drop_q          <= 1'b0;
      i_pend_q        <= 1'b0;
      i_slot_addr_q   <= 32'd0;
      d_pend_q        <= 1'b0;
      d_slot_write_q  <= 1'b0;
      d_slot_addr_q   <= 32'd0;
      d_slot_wdata_q  <= 32'd0;
      d_slot_wmask_q  <= 32'd0;
      mem_start_q     <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_addr_q      <= 32'd0;
      mem_wdata_q     <= 32'd0;
      mem_wmask_q     <= 32'd0;
      i_inst_q        <= 32'd0;
      i_valid_q       <= 1'b0;
      d_rdata_q       <= 32'd0;
      d_rdata_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_data_q     <= last_data_d;
      drop_q          <= drop_d;
      i_pend_q        <= i_pend_d;
      i_slot_addr_q   <= i_slot_addr_d;
      d_pend_q        <= d_pend_d;
      d_slot_write_q  <= d_slot_write_d;
      d_slot_addr_q   <= d_slot_addr_d;
      d_slot_wdata_q  <= d_slot_wdata_d;
      d_slot_wmask_q  <= d_slot_wmask_d;
      mem_start_q     <= mem_start_d;
      mem_write_q     <= mem_write_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wmask_q     <= mem_wmask_d;
      i_inst_q        <= i_inst_d;
      i_valid_q       <= i_valid_d;
      d_rdata_q       <= d_rdata_d;
      d_rdata_valid_q <= d_rdata_valid_d;
    end
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The module SHALL have parameter FIRST_GRANT_DATA, default 1, meaning that after reset the first tie is granted to the data port (1) or the instruction port (0).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port i_start, input, 1 bit: instruction-fetch request strobe.
REQ-005 The module SHALL have port i_ready, output, 1 bit: the instruction port can accept a request.
REQ-006 The module SHALL have port i_addr, input, 32 bits: fetch address.
REQ-007 The module SHALL have port i_flush, input, 1 bit: discard the fetch request that is pending or in flight (branch hazard).
REQ-008 The module SHALL have port i_inst, output, 32 bits: fetched word.
REQ-009 The module SHALL have port i_valid, output, 1 bit: i_inst is valid (single-cycle pulse).
REQ-010 The module SHALL have port d_start, input, 1 bit: data request strobe.
REQ-011 The module SHALL have port d_write, input, 1 bit: data request is a write (1) or a read (0).
REQ-012 The module SHALL have port d_ready, output, 1 bit: the data port can accept a request.
REQ-013 The module SHALL have ports d_addr, d_wdata and d_wmask, input, 32 bits each: data request address, write data and write mask.
REQ-014 The module SHALL have port d_rdata, output, 32 bits: read data.
REQ-015 The module SHALL have port d_rdata_valid, output, 1 bit: d_rdata is valid (single-cycle pulse).
REQ-016 The module SHALL have ports mem_start, mem_write, mem_addr, mem_wdata and mem_wmask, outputs of 1/1/32/32/32 bits: the shared downstream memory command.
REQ-017 The module SHALL have port mem_ready, input, 1 bit: memory accepts a command.
REQ-018 The module SHALL have ports mem_rdata (input, 32 bits) and mem_rdata_valid (input, 1 bit): memory read response.

Function
REQ-019 The module SHALL accept a request on a port when its start and ready are both high in the same cycle, capturing addr/write/wdata/wmask into that port's pending slot at that edge; instruction requests are always reads.
REQ-020 A port's ready SHALL be high only while its pending slot is empty and the port owns no in-flight transaction.
REQ-021 Simultaneous i_start and d_start SHALL both be accepted into their separate slots.
REQ-022 The FSM SHALL have states IDLE, ISSUE and WAIT_RESP.
REQ-023 In IDLE with at least one pending slot, the FSM SHALL grant one port and go to ISSUE on the next edge; if both slots are pending, it SHALL grant the port not granted last (round-robin), with the initial tie set by FIRST_GRANT_DATA.
REQ-024 In ISSUE, mem_start SHALL be 1 and mem_* SHALL reflect the granted slot; with mem_ready=1 the command completes, the slot is freed and the FSM goes to WAIT_RESP for a read or to IDLE for a write; with mem_ready=0 it holds all of mem_* stable.
REQ-025 In WAIT_RESP, on mem_rdata_valid=1 the module SHALL register mem_rdata to the owner's i_inst or d_rdata, pulse the owner's valid for exactly one cycle on the next cycle, and go to IDLE.
REQ-026 Minimum latency SHALL be: accept at edge N, mem_start high in cycle N+2, owner valid one cycle after mem_rdata_valid.
REQ-027 mem_rdata_valid SHALL be ignored in IDLE and ISSUE.
REQ-028 The module SHALL handle i_flush=1 as follows: a pending, unissued fetch slot is cleared; if the fetch is in ISSUE, the command still completes but its response is dropped (no i_valid); if it is in WAIT_RESP, the response is consumed and i_valid is suppressed.
REQ-029 i_flush SHALL never affect the data port; a same-cycle i_start with i_flush is accepted as a new request.
REQ-030 i_inst and d_rdata SHALL hold their last value between pulses.

Reset
REQ-031 On rst_n=0, the module SHALL immediately (asynchronously) enter IDLE, clear pending slots and the in-flight owner, set the last-grant pointer per FIRST_GRANT_DATA, and drive mem_start, i_valid and d_rdata_valid to 0, all 32-bit outputs to 0, and i_ready and d_ready to 1 once rst_n is released.
REQ-032 Reset mid-transaction SHALL abandon the transaction, and any later mem_rdata_valid SHALL be ignored.

Verification
REQ-033 Single fetch: i_addr=0x100 accepted at edge 0, mem_ready=1, mem_rdata=0x00000013 valid 3 cycles later -> mem_start in cycle 2 with mem_addr=0x100, then i_inst=0x13 and i_valid for 1 cycle.
REQ-034 Tie: i_start and d_start (read, 0x2000) in the same cycle, FIRST_GRANT_DATA=1 -> data issued first, fetch issued next; repeat the tie -> fetch first.
REQ-035 Write: d_write=1, d_addr=0x3000, d_wdata=0xDEADBEEF, d_wmask=0xFFFFFFFF, mem_ready low for 4 cycles -> mem_* held stable, completion without d_rdata_valid, d_ready back to 1.
REQ-036 Flush: fetch in WAIT_RESP, i_flush pulsed -> response consumed, i_valid stays 0, next fetch served normally.
REQ-037 Reset: rst_n low during WAIT_RESP, then mem_rdata_valid=1 -> no valid pulse, all outputs at reset values.
